// File: rtl/m16_frame_filler_if.sv
// Requester/serializer side of the M16 frame filler: channel requests, data, switch toggle and buffer write port.
// The filler uses the slave modport; whatever drives requests and observes writes uses master.
interface m16_frame_filler_if;
  logic        iSwitch;
  logic [3:0]  iReq;
  logic [43:0] iData;
  logic [3:0]  oAck;
  logic [11:0] oWrAddr;
  logic [11:0] oWrData;
  logic        oWrEn;
  logic        oFull;
  logic        oUnderrun;
  logic [11:0] oFillCnt;

  modport master (
    output iSwitch, iReq, iData,
    input  oAck, oWrAddr, oWrData, oWrEn, oFull, oUnderrun, oFillCnt
  );

  modport slave (
    input  iSwitch, iReq, iData,
    output oAck, oWrAddr, oWrData, oWrEn, oFull, oUnderrun, oFillCnt
  );
endinterface

// File: rtl/m16_frame_filler.sv
// Round-robin fill of the idle ping-pong half: header word (frame counter) then 2047 channel words.
// Ack is combinational (one word per cycle); writes appear one cycle after accept; a full half refuses further accepts.
module m16_frame_filler (
  input  logic                     iClkOrb,
  input  logic                     reset,
  m16_frame_filler_if.slave        bus
);
  typedef enum logic [1:0] {HDR, FILL, FULL} state_t;

  state_t      state_q, state_d;
  logic        sw_prev_q;
  logic        wr_half_q, wr_half_d;
  logic [11:0] cnt_q, cnt_d;
  logic [10:0] frm_cnt_q, frm_cnt_d;
  logic [1:0]  rr_q, rr_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [11:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        full_q, full_d;
  logic        underrun_q, underrun_d;

  logic        sw_edge;
  logic        any_req;
  logic        accept;
  logic [1:0]  grant;
  logic [1:0]  idx;
  logic [10:0] sel_dat;

  assign sw_edge = bus.iSwitch ^ sw_prev_q;

  // Descending scan so the channel closest to rr_q is the one left in grant.
  always_comb begin
    grant   = rr_q;
    any_req = 1'b0;
    idx     = rr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_q + 2'(i);
      if (bus.iReq[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

  // Reset gating keeps an ack from being shown for a word the reset edge would discard.
  assign accept   = (state_q == FILL) && !sw_edge && !reset && any_req;
  assign bus.oAck = accept ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    case (grant)
      2'd0:    sel_dat = bus.iData[10:0];
      2'd1:    sel_dat = bus.iData[21:11];
      2'd2:    sel_dat = bus.iData[32:22];
      default: sel_dat = bus.iData[43:33];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_half_d  = wr_half_q;
    cnt_d      = cnt_q;
    frm_cnt_d  = frm_cnt_q;
    rr_d       = rr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    underrun_d = 1'b0;
    if (sw_edge) begin
      wr_half_d  = ~bus.iSwitch;
      cnt_d      = 12'd0;
      state_d    = HDR;
      underrun_d = (state_q != FULL);
    end else begin
      case (state_q)
        HDR: begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_half_q, 11'd0};
          wr_data_d = {1'b0, frm_cnt_q};
          frm_cnt_d = frm_cnt_q + 11'd1;
          cnt_d     = 12'd1;
          state_d   = FILL;
        end
        FILL: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_half_q, cnt_q[10:0]};
            wr_data_d = {1'b0, sel_dat};
            cnt_d     = cnt_q + 12'd1;
            rr_d      = grant + 2'd1;
            if (cnt_q == 12'd2047) state_d = FULL;
          end
        end
        default: ;
      endcase
    end
    full_d = (state_d == FULL);
  end

  always_ff @(posedge iClkOrb) begin
    if (reset) begin
      state_q    <= HDR;
      sw_prev_q  <= 1'b0;
      wr_half_q  <= 1'b1;
      cnt_q      <= 12'd0;
      frm_cnt_q  <= 11'd0;
      rr_q       <= 2'd0;
      wr_addr_q  <= 12'd0;
      wr_data_q  <= 12'd0;
      wr_en_q    <= 1'b0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_prev_q  <= bus.iSwitch;
      wr_half_q  <= wr_half_d;
      cnt_q      <= cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      rr_q       <= rr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.oWrAddr   = wr_addr_q;
  assign bus.oWrData   = wr_data_q;
  assign bus.oWrEn     = wr_en_q;
  assign bus.oFull     = full_q;
  assign bus.oUnderrun = underrun_q;
  assign bus.oFillCnt  = cnt_q;
endmodule

// File: doc/m16_frame_filler.md
# m16_frame_filler

Write-side controller for the M16 orbit frame ping-pong buffer. It arbitrates four requester channels round-robin, writes their 11-bit words into the buffer half the serializer is not reading, and stamps an 11-bit frame counter into word 0 of each frame. It tracks the serializer's half-switch toggle to swap halves, signals when a half is full, and flags a half that was not completely filled before the swap (underrun).

## Interface
- No parameters. Frame length is fixed at 2048 words, with 12-bit buffer words and 4 channels.
- iClkOrb  in  1  orbit clock; the serializer runs on the same clock.
- reset  in  1  synchronous, active-high.
- iSwitch  in  1  half-select toggle from the serializer; the serializer reads half iSwitch.
- iReq  in  4  per-channel request; held high until acknowledged.
- iData  in  44  channel k data at bits [11k+10 : 11k].
- oAck  out  4  one-hot, combinational; data is accepted on the clock edge where iReq[k] and oAck[k] are both high.
- oWrAddr  out  12  {half, index[10:0]}, registered.
- oWrData  out  12  {1'b0, 11-bit payload}, registered; bit 11 is always 0 because it is reserved for serializer markers.
- oWrEn  out  1  write strobe, registered, one cycle per word.
- oFull  out  1  current half holds 2048 words; no further accepts.
- oUnderrun  out  1  one-cycle pulse on a half swap when the previous fill was incomplete.
- oFillCnt  out  12  words written to the current half, 0..2048.

## Operation
- Internal registers:
  - swPrev: previous iSwitch.
  - wrHalf: the half being written.
  - cnt: 12 bits.
  - frmCnt: 11 bits.
  - rr: 2-bit round-robin pointer.
  - state: one of HDR, FILL, FULL.
- Reset values: swPrev=0, wrHalf=1, cnt=0, frmCnt=0, rr=0, state=HDR. All outputs are 0: oAck, oWrAddr, oWrData, oWrEn, oFull, oUnderrun, oFillCnt.
- edge = iSwitch XOR swPrev. swPrev <= iSwitch every cycle.
- Edge handling takes priority over all states:
  - oAck is forced to 0.
  - wrHalf <= ~iSwitch, cnt <= 0, state <= HDR.
  - oUnderrun <= 1 if state != FULL, otherwise 0.
- HDR state:
  - oAck = 0.
  - Write {wrHalf, 11'd0} with data {1'b0, frmCnt}.
  - frmCnt <= frmCnt+1, wrapping 2047 -> 0.
  - cnt <= 1, state <= FILL.
- FILL state:
  - g = first channel with iReq high, searching rr, rr+1, rr+2, rr+3 (mod 4). oAck[g]=1 and all other acks are 0. No request means no ack.
  - On accept: write {wrHalf, cnt[10:0]} with data {1'b0, iData[g]}, cnt <= cnt+1, rr <= g+1 (mod 4).
  - rr does not change when there is no accept.
  - If cnt==2047 and an accept occurs: cnt <= 2048, state <= FULL.
- FULL state: oAck=0, oFull=1. The block holds until an edge.
- Outputs: oFull = (state==FULL), registered. oFillCnt = cnt, registered.
- Reset asserted mid-fill: all state returns to reset values on the next edge. No write is issued in the cycle following that edge.

## Timing
- oAck is combinational from state, rr, swPrev, iSwitch and iReq, and is valid in the same cycle as the request.
- An accept at clock edge N produces oWrEn=1 with that word's address and data in the cycle after edge N. oWrEn returns to 0 the next cycle unless another accept occurs.
- Throughput is one word per cycle in FILL.
- HDR lasts exactly 1 cycle. The first channel accept can occur on the edge 2 cycles after the switch edge.
- After reset release, the HDR write occurs on the first clock edge, with half 1 and frmCnt 0.
- oUnderrun is high for exactly 1 cycle, the cycle after the edge is detected.
- A full half takes 1 header word plus 2047 data words.

## Test plan
- Reset, then release with iSwitch=0 and iReq=0 -> one cycle later: oWrEn=1, oWrAddr=0x800, oWrData=0x000, oFillCnt=1. After that no writes and oAck=0.
- All four iReq held high, with channel k data = 0x100+k -> acks rotate 0,1,2,3,0,...; writes go to 0x801, 0x802, ... with data 0x100, 0x101, ...; after 2047 accepts oFull=1 and oFillCnt=2048, and oAck stays 0.
- Only iReq[2] high -> oAck=4'b0100 every cycle and consecutive addresses are written. When iReq[0] rises, ack alternates 0,2,0,2.
- iSwitch toggles 0->1 at oFillCnt=100 -> oUnderrun pulses once, no ack in the edge cycle or the HDR cycle, header written to 0x000 with data 0x001, and the channel fill resumes at 0x001.
- iSwitch toggles while in FULL -> oUnderrun stays 0, oFull drops, and the header is written to the opposite half.
- Apply 2048 switch toggles -> header payload wraps to 0x000. Channel data with bit 10 set is written with oWrData[11]=0. A reset asserted mid-fill causes no oWrEn in the following cycle.
